// File: rtl/cpu_axi_sched.sv
// Single-outstanding scheduler sharing one AXI master between the CPU inst and data
// sram-like ports: data has priority, one AR/R or AW/W/B sequence in flight at a time.
module cpu_axi_sched #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

  state_t      state, state_nxt;
  logic        own_data;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        aw_done, w_done;
  logic        grant_data, grant_inst;
  logic        rid_unused;

  function automatic logic [3:0] wr_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = 4'b0011 << {off[1], 1'b0};
      default: s = 4'hF;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Routing follows the latched owner, so the returned ID is deliberately ignored.
  assign rid_unused = ^rid;

  always_comb begin
    state_nxt  = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state)
      IDLE: begin
        if (data_req) begin
          grant_data = 1'b1;
          state_nxt  = data_wr ? WR_ADDR : RD_ADDR;
        end else if (inst_req && !inst_wr) begin
          grant_inst = 1'b1;
          state_nxt  = RD_ADDR;
        end
      end
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid) state_nxt = IDLE;
      WR_ADDR: if (aw_done && w_done) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      own_data  <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_data || grant_inst) begin
        own_data  <= grant_data;
        lat_size  <= grant_data ? data_size : inst_size;
        lat_addr  <= grant_data ? data_addr : inst_addr;
        lat_wdata <= grant_data ? data_wdata : 32'd0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (state == WR_ADDR) begin
        if (awready) aw_done <= 1'b1;
        if (wready)  w_done  <= 1'b1;
      end
    end
  end

  // Every handshake output is forced low while reset is held.
  assign data_addr_ok = resetn && grant_data;
  assign inst_addr_ok = resetn && grant_inst;
  assign arvalid      = resetn && (state == RD_ADDR);
  assign rready       = resetn && (state == RD_DATA);
  assign awvalid      = resetn && (state == WR_ADDR) && !aw_done;
  assign wvalid       = resetn && (state == WR_ADDR) && !w_done;
  assign bready       = resetn && (state == WR_RESP);

  assign inst_data_ok = resetn && (state == RD_DATA) && rvalid && !own_data;
  assign data_data_ok = resetn && (((state == RD_DATA) && rvalid && own_data) ||
                                   ((state == WR_RESP) && bvalid));

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

  assign arid   = own_data ? DATA_ID : INST_ID;
  assign araddr = lat_addr;
  assign arsize = {1'b0, lat_size};
  assign awaddr = lat_addr;
  assign awsize = {1'b0, lat_size};
  assign wstrb  = wr_strobe(lat_size, lat_addr[1:0]);
  assign wdata  = lane_data(lat_size, lat_wdata);

endmodule

// File: tb/tb_cpu_axi_sched.sv
// Bench for cpu_axi_sched: plays CPU and AXI slave, predicting grants, AXI payloads
// and completions from a per-transaction model.
module tb_cpu_axi_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_axi_sched dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte b is enabled when it lies in the same naturally aligned chunk as addr.
  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
    int bytes;
    logic [3:0] s;
    bytes = 1 << size;
    s = 4'd0;
    for (int b = 0; b < 4; b++)
      if (b / bytes == int'(addr[1:0]) / bytes) s[b] = 1'b1;
    return s;
  endfunction

  // Reference: lane b carries source byte (b mod access width).
  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] d);
    int bytes;
    logic [31:0] r;
    bytes = 1 << size;
    r = 32'd0;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = d[(b % bytes)*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // One granted transaction from request to completion. inst_req stays at i_req
  // throughout, so a losing inst request remains pending for the next call.
  task automatic run_txn(input bit d_req, input bit d_wr, input logic [1:0] d_size,
                         input logic [31:0] d_addr, input logic [31:0] d_wd,
                         input bit i_req, input logic [1:0] i_size, input logic [31:0] i_addr,
                         input int ad, input int rd, input int awd, input int wd,
                         input logic [31:0] rdv);
    bit own_d, wr, got;
    logic [1:0] sz;
    logic [31:0] ad_q;
    int c, last;
    own_d = d_req;
    wr    = d_req && d_wr;
    sz    = d_req ? d_size : i_size;
    ad_q  = d_req ? d_addr : i_addr;
    tick();
    resetn = 1'b1;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    data_req = d_req; data_wr = d_wr; data_size = d_size; data_addr = d_addr; data_wdata = d_wd;
    inst_req = i_req; inst_wr = 1'b0; inst_size = i_size; inst_addr = i_addr;
    #1;
    check("idle_outputs", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    check("idle_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("grant", 32'({data_addr_ok, inst_addr_ok}), own_d ? 32'd2 : 32'd1);
    c = 0;
    tick(); c++;
    data_req = 1'b0;
    if (!own_d) inst_req = 1'b0;
    if (!wr) begin
      for (int k = 0; k <= ad; k++) begin
        if (k > 0) begin tick(); c++; end
        arready = (k == ad);
        #1;
        check("arvalid", 32'(arvalid), 32'd1);
        check("araddr", araddr, ad_q);
        check("arid", 32'(arid), own_d ? 32'd1 : 32'd0);
        check("arsize", 32'(arsize), 32'(sz));
        check("ar_no_ok", 32'({inst_data_ok, data_data_ok, data_addr_ok, inst_addr_ok}), 32'd0);
      end
      for (int k = 0; k <= rd; k++) begin
        tick(); c++;
        arready = 1'b0;
        rvalid  = (k == rd);
        rdata   = (k == rd) ? rdv : $urandom;
        rid     = 4'($urandom);
        #1;
        check("rready", 32'(rready), 32'd1);
        check("r_arvalid", 32'(arvalid), 32'd0);
        check("r_addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
        if (k < rd) check("r_early_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        else begin
          check("r_data_ok", 32'({data_data_ok, inst_data_ok}), own_d ? 32'd2 : 32'd1);
          check("inst_rdata", inst_rdata, rdv);
          check("data_rdata", data_rdata, rdv);
        end
      end
    end else begin
      last = (awd > wd) ? awd : wd;
      for (int t = 0; t <= last; t++) begin
        if (t > 0) begin tick(); c++; end
        awready = (t == awd);
        wready  = (t == wd);
        #1;
        check("awvalid", 32'(awvalid), 32'(t <= awd));
        check("wvalid", 32'(wvalid), 32'(t <= wd));
        check("awaddr", awaddr, ad_q);
        check("awsize", 32'(awsize), 32'(sz));
        check("wstrb", 32'(wstrb), 32'(exp_strb(sz, ad_q)));
        check("wdata", wdata, exp_wdata(sz, d_wd));
        check("w_no_ok", 32'({inst_data_ok, data_data_ok, bready}), 32'd0);
      end
      got = 1'b0;
      for (int n = 0; n < 4 && !got; n++) begin
        tick(); c++;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        check("b_valids_low", 32'({awvalid, wvalid, arvalid}), 32'd0);
        check("b_inst_ok", 32'(inst_data_ok), 32'd0);
        if (data_data_ok) begin
          got = 1'b1;
          check("bready", 32'(bready), 32'd1);
          check("wr_latency", 32'(c >= 3), 32'd1);
        end
      end
      if (!got) check("b_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1234;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h5678; data_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("rst_addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
      check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
      if (i > 0) check("rst_araddr", araddr, 32'd0);
    end

    run_txn(0, 0, 2'd2, 32'd0, 32'd0, 1, 2'd2, 32'hBFC00000, 0, 0, 0, 0, 32'h3C080001);
    run_txn(1, 0, 2'd2, 32'h80000004, 32'd0, 1, 2'd2, 32'hBFC00004, 0, 1, 0, 0, 32'hCAFEF00D);
    run_txn(0, 0, 2'd2, 32'd0, 32'd0, 1, 2'd2, 32'hBFC00004, 0, 0, 0, 0, 32'h0000000C);
    run_txn(1, 1, 2'd0, 32'h80000003, 32'h000000AB, 0, 2'd2, 32'd0, 0, 0, 3, 0, 32'd0);
    run_txn(1, 1, 2'd1, 32'h80000002, 32'h00001234, 0, 2'd2, 32'd0, 0, 0, 0, 2, 32'd0);
    run_txn(1, 1, 2'd2, 32'h80000010, 32'hDEADBEEF, 0, 2'd2, 32'd0, 0, 0, 1, 1, 32'd0);
    run_txn(1, 0, 2'd1, 32'h80000022, 32'd0, 0, 2'd2, 32'd0, 5, 0, 0, 0, 32'h55AA00FF);

    // An inst write is never granted.
    tick();
    inst_req = 1'b1; inst_wr = 1'b1; data_req = 1'b0;
    #1;
    check("iwr_addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
    tick();
    inst_req = 1'b0; inst_wr = 1'b0;
    #1;
    check("iwr_idle", 32'({arvalid, awvalid}), 32'd0);

    // Reset while a read sits in RD_DATA.
    tick();
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h00001000;
    #1;
    check("rr_grant", 32'(inst_addr_ok), 32'd1);
    tick();
    inst_req = 1'b0; arready = 1'b1;
    #1;
    check("rr_arvalid", 32'(arvalid), 32'd1);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h11112222; resetn = 1'b0;
    #1;
    check("rr_gated", 32'({rready, inst_data_ok, data_data_ok}), 32'd0);
    run_txn(0, 0, 2'd2, 32'd0, 32'd0, 1, 2'd2, 32'h00002000, 0, 0, 0, 0, 32'h33334444);

    for (int i = 0; i < 60; i++) begin
      bit dr, dw, ir;
      logic [1:0] ds, is;
      dr = 1'($urandom);
      ir = dr ? 1'($urandom) : 1'b1;
      dw = 1'($urandom);
      ds = 2'($urandom_range(0, 2));
      is = 2'($urandom_range(0, 2));
      run_txn(dr, dw, ds, $urandom, $urandom, ir, is, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_axi_sched.md
Name: cpu_axi_sched

Overview:
- Single-outstanding scheduler that shares one AXI master between the instruction and data sram-like ports of the CPU.
- Arbitrates requests, with fixed priority data > inst, and sequences AR/R or AW/W/B for the granted request.
- Generates AXI size, strobe and lane-replicated write data, and routes addr_ok/data_ok back to the owner.
- Sits between the CPU core and the top-level AXI wrapper. The wrapper ties off the unused AXI fields: len=0, burst=INCR, lock/cache/prot=0, wlast=1, awid/wid=DATA_ID.

Parameters:
- INST_ID, 4'd0, arid driven for instruction fetches.
- DATA_ID, 4'd1, arid driven for data reads.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- inst_req  in  1  inst sram-like request
- inst_wr  in  1  inst write; must be 0, write requests are never accepted
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_rdata  out  32  read data, valid with inst_data_ok
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  read complete
- data_req  in  1  data request
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  32  byte address
- data_wdata  in  32  store data, right-aligned
- data_rdata  out  32  read data, valid with data_data_ok
- data_addr_ok  out  1  request accepted
- data_data_ok  out  1  read/write complete
- arid  out  4  read ID
- araddr  out  32  read address
- arsize  out  3  read size
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R ID
- rdata  in  32  R data
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  32  write address
- awsize  out  3  write size
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bvalid  in  1  B valid
- bready  out  1  B ready

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. While reset is asserted:
  - state=IDLE;
  - all AXI valids/readies, addr_ok and data_ok outputs are 0;
  - latched registers are 0;
  - any in-flight transaction is abandoned.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE grant:
  - If data_req=1, grant data.
  - Else if inst_req=1 and inst_wr=0, grant inst.
  - The granted port's addr_ok is asserted combinationally in the same cycle. Both addr_ok outputs are never high together.
- On grant, the block latches owner, wr, size, addr and wdata.
- Next state after grant: RD_ADDR for a read, WR_ADDR for a write.
- inst_req with inst_wr=1 is never granted; the block stays in IDLE.
- RD_ADDR:
  - arvalid=1; araddr=latched addr; arsize={1'b0,size}; arid=INST_ID or DATA_ID per owner.
  - arvalid and payload are held stable until arready=1, then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, the owner's data_ok pulses for exactly 1 cycle, rdata passes through unmodified (CPU does lane extraction), and the next state is IDLE.
  - rid is not examined; routing uses the latched owner.
- WR_ADDR:
  - awvalid=1 and wvalid=1 both assert on entry.
  - Each drops the cycle after its own handshake, tracked by aw_done/w_done.
  - The two handshakes may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP; this happens in the cycle following the last handshake.
- WR_RESP: bready=1; on bvalid, data_data_ok pulses for 1 cycle, then IDLE.
- Write strobes:
  - size0: wstrb = 4'b0001 << addr[1:0].
  - size1: wstrb = 4'b0011 << {addr[1],1'b0}.
  - size2: 4'hF.
- Write data: size0 gives {4{wdata[7:0]}}; size1 gives {2{wdata[15:0]}}; size2 gives wdata.
- awaddr=latched addr; awsize={1'b0,size}.
- rdata outputs: inst_rdata=rdata and data_rdata=rdata at all times; they are meaningful only with data_ok.
- Occupancy and latency:
  - At most one AXI transaction is outstanding.
  - No new grant is made in the cycle data_ok pulses; the earliest next addr_ok is the cycle after.
- Minimum latency:
  - Read: addr_ok(c0), arvalid(c1), data_ok no earlier than c2.
  - Write: addr_ok(c0), aw/w (c1), data_ok no earlier than c3.
- Starvation: a continuously asserted data_req starves inst by design; the CPU guarantees gaps.

Test Plan:
- Inst fetch: inst_req=1, inst_addr=0xBFC00000 -> inst_addr_ok in same cycle, arid=0, araddr=0xBFC00000, arsize=2. With rvalid and rdata=0x3C080001 two cycles later -> inst_data_ok pulses 1 cycle and inst_rdata=0x3C080001.
- Simultaneous data_req (read, addr 0x80000004) and inst_req -> data granted first with arid=1. Inst is granted in the cycle after data_data_ok.
- Store byte: size=0, addr=0x80000003, wdata=0x000000AB -> wstrb=4'b1000, wdata=0xABABABAB. awready is delayed 3 cycles while wready is immediate -> wvalid drops after 1 cycle, WR_RESP is entered only after the AW handshake, and data_data_ok follows bvalid.
- Halfword store at addr 0x80000002, wdata=0x1234 -> wstrb=4'b1100, wdata=0x12341234, awsize=1. A word store gives wstrb=4'hF.
- arready held low 5 cycles -> arvalid, araddr and arid stay stable for all 5 cycles, and no data_ok is asserted.
- Reset asserted during RD_DATA -> the next cycle has all valids/readies and data_ok at 0 and state IDLE. A new inst_req is granted immediately after reset is released.
